stereo_frame_serializer: RTL and testbench



---
 rtl/stereo_frame_serializer_if.sv | 27 ++
 rtl/stereo_frame_serializer.sv | 172 +++++++++++++++++
 tb/tb_stereo_frame_serializer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stereo_frame_serializer_if.sv
// Frame-in / word-out bus of the stereo frame serializer.
// master = surrounding logic (effect core and encoder side), slave = the serializer.
interface stereo_frame_serializer_if #(
    parameter int unsigned in_width    = 24,
    parameter int unsigned audio_width = 16
);
    logic                   i_valid;
    logic                   i_ready;
    logic [in_width-1:0]    i_left;
    logic [in_width-1:0]    i_right;
    logic                   i_is_error;
    logic                   o_valid;
    logic                   o_ready;
    logic [audio_width-1:0] o_audio;
    logic                   o_is_left;
    logic                   o_is_error;

    modport master (
        output i_valid, i_left, i_right, i_is_error, o_ready,
        input  i_ready, o_valid, o_audio, o_is_left, o_is_error
    );

    modport slave (
        input  i_valid, i_left, i_right, i_is_error, o_ready,
        output i_ready, o_valid, o_audio, o_is_left, o_is_error
    );
endinterface

// File: rtl/stereo_frame_serializer.sv
// Buffers up to two stereo frames and emits them as a left/right word stream with width reduction.
// Define STEREO_SERIALIZER_ROUND_EN for round-half-up with saturation; otherwise samples are truncated.
module stereo_frame_serializer #(
    parameter int unsigned in_width    = 24,
    parameter int unsigned audio_width = 16
) (
    input  logic clk,
    input  logic reset,
    stereo_frame_serializer_if.slave bus
);
    localparam int unsigned shift = in_width - audio_width;

    typedef struct packed {
        logic [in_width-1:0] left;
        logic [in_width-1:0] right;
        logic                error;
    } frame_t;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

`ifdef STEREO_SERIALIZER_ROUND_EN
    localparam logic [in_width:0] half = (in_width + 1)'(1) << (shift - 1);
`endif

    // Reduce one processing-width sample to the transport width.
    function automatic logic [audio_width-1:0] reduce(input logic [in_width-1:0] x);
`ifdef STEREO_SERIALIZER_ROUND_EN
        logic [in_width:0]                sum;
        logic [in_width:0]                sh;
        logic [in_width-audio_width+1:0]  top;
        sum = {x[in_width-1], x} + half;
        sh  = $unsigned($signed(sum) >>> shift);
        top = sh[in_width:audio_width-1];
        if ((&top) || !(|top))
            return sh[audio_width-1:0];
        else if (sh[in_width])
            return {1'b1, {(audio_width-1){1'b0}}};
        else
            return {1'b0, {(audio_width-1){1'b1}}};
`else
        logic unused_lsbs;
        unused_lsbs = ^x[shift-1:0];
        return x[in_width-1 -: audio_width];
`endif
    endfunction

    frame_t                 mem [2];
    frame_t                 in_frame;
    frame_t                 head;
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             count;
    logic [1:0]             count_next;
    logic                   push;
    logic                   pop;
    logic [in_width-1:0]    next_left;
    logic                   next_error;

    state_t                 state;
    state_t                 state_next;
    logic                   ready_q;
    logic                   valid_q;
    logic [audio_width-1:0] audio_q;
    logic                   is_left_q;
    logic                   is_error_q;
    logic                   valid_d;
    logic [audio_width-1:0] audio_d;
    logic                   is_left_d;
    logic                   is_error_d;

    assign in_frame   = '{left: bus.i_left, right: bus.i_right, error: bus.i_is_error};
    assign head       = mem[rd_ptr];
    assign push       = bus.i_valid && ready_q;
    assign pop        = (state == RIGHT) && bus.o_ready;
    assign count_next = count + 2'(push) - 2'(pop);

    // With a full FIFO the follow-on frame is the second entry; otherwise it is the one arriving now.
    assign next_left  = (count == 2'd2) ? mem[~rd_ptr].left  : bus.i_left;
    assign next_error = (count == 2'd2) ? mem[~rd_ptr].error : bus.i_is_error;

    // Frame storage, no reset needed: contents are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_frame;
    end

    // FIFO pointers, occupancy and the registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count   <= count_next;
            ready_q <= (count_next < 2'd2);
        end
    end

    // Phase FSM state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            audio_q    <= '0;
            is_left_q  <= 1'b1;
            is_error_q <= 1'b0;
        end else begin
            state      <= state_next;
            valid_q    <= valid_d;
            audio_q    <= audio_d;
            is_left_q  <= is_left_d;
            is_error_q <= is_error_d;
        end
    end

    // Next phase and next output word.
    always_comb begin
        state_next = state;
        valid_d    = valid_q;
        audio_d    = audio_q;
        is_left_d  = is_left_q;
        is_error_d = is_error_q;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    state_next = LEFT;
                    valid_d    = 1'b1;
                    audio_d    = reduce(head.left);
                    is_left_d  = 1'b1;
                    is_error_d = head.error;
                end
            end
            LEFT: begin
                if (bus.o_ready) begin
                    state_next = RIGHT;
                    audio_d    = reduce(head.right);
                    is_left_d  = 1'b0;
                end
            end
            RIGHT: begin
                if (bus.o_ready) begin
                    if ((count == 2'd2) || push) begin
                        state_next = LEFT;
                        audio_d    = reduce(next_left);
                        is_left_d  = 1'b1;
                        is_error_d = next_error;
                    end else begin
                        state_next = IDLE;
                        valid_d    = 1'b0;
                        is_left_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_d    = 1'b0;
                is_left_d  = 1'b1;
            end
        endcase
    end

    assign bus.i_ready    = ready_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_audio    = audio_q;
    assign bus.o_is_left  = is_left_q;
    assign bus.o_is_error = is_error_q;
endmodule

// File: tb/tb_stereo_frame_serializer.sv
// Self-checking bench for stereo_frame_serializer: directed vector table, hand sequences,
// and randomized traffic against a frame-queue reference model.
module tb_stereo_frame_serializer;
    localparam int unsigned in_width    = 24;
    localparam int unsigned audio_width = 16;

    typedef struct {
        logic [audio_width-1:0] audio;
        logic                   is_left;
        logic                   err;
    } word_t;

    typedef struct {
        logic [in_width-1:0]    l;
        logic [in_width-1:0]    r;
        logic                   e;
        logic [audio_width-1:0] xl;
        logic [audio_width-1:0] xr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stereo_frame_serializer_if #(.in_width(in_width), .audio_width(audio_width)) bus ();

    stereo_frame_serializer #(.in_width(in_width), .audio_width(audio_width)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int    n_vec = 0;
    int    n_err = 0;
    word_t exp_q[$];
    int    model_cnt;
    logic  exp_ready;
    logic  hold_prev;
    word_t held;
    logic  last_push;

    // Reference reduction using integer arithmetic on the signed sample value.
    function automatic logic [audio_width-1:0] ref_reduce(input logic [in_width-1:0] x);
        longint v;
        longint r;
        v = longint'($signed(x));
`ifdef STEREO_SERIALIZER_ROUND_EN
        r = (v + (longint'(1) << (in_width - audio_width - 1))) >>> (in_width - audio_width);
        if (r > (longint'(1) << (audio_width - 1)) - 1) r = (longint'(1) << (audio_width - 1)) - 1;
        if (r < -(longint'(1) << (audio_width - 1)))    r = -(longint'(1) << (audio_width - 1));
`else
        r = v >>> (in_width - audio_width);
`endif
        return audio_width'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [in_width-1:0] l, input logic [in_width-1:0] r,
                         input logic e, input logic rdy);
        bus.i_valid    = v;
        bus.i_left     = l;
        bus.i_right    = r;
        bus.i_is_error = e;
        bus.o_ready    = rdy;
    endtask

    // One clock: check this cycle's transfers against the model, then advance.
    task automatic tick();
        word_t w;
        logic  pa;
        logic  wa;
        pa = bus.i_valid && bus.i_ready && !reset;
        wa = bus.o_valid && bus.o_ready && !reset;
        if (!reset) begin
            chk("i_ready", 32'(bus.i_ready), 32'(exp_ready));
            if (hold_prev) begin
                chk("hold_valid", 32'(bus.o_valid), 32'd1);
                chk("hold_word", 32'({bus.o_audio, bus.o_is_left, bus.o_is_error}),
                    32'({held.audio, held.is_left, held.err}));
            end
            if (wa) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h, expected no word", bus.o_audio);
                end else begin
                    w = exp_q.pop_front();
                    chk("word", 32'({bus.o_audio, bus.o_is_left, bus.o_is_error}),
                        32'({w.audio, w.is_left, w.err}));
                    if (!w.is_left) model_cnt--;
                end
            end
            if (pa) begin
                exp_q.push_back('{ref_reduce(bus.i_left),  1'b1, bus.i_is_error});
                exp_q.push_back('{ref_reduce(bus.i_right), 1'b0, bus.i_is_error});
                model_cnt++;
            end
        end
        hold_prev = bus.o_valid && !bus.o_ready && !reset;
        held      = '{bus.o_audio, bus.o_is_left, bus.o_is_error};
        last_push = pa;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            model_cnt = 0;
            exp_ready = 1'b0;
            hold_prev = 1'b0;
        end else begin
            exp_ready = (model_cnt < 2);
        end
    endtask

    vec_t                vecs [5];
    logic [in_width-1:0] bp_l [3];
    logic [in_width-1:0] bp_r [3];
    logic [31:0]         rnd;
    logic [in_width-1:0] corner [4];

    initial begin
`ifdef STEREO_SERIALIZER_ROUND_EN
        vecs[0] = '{24'h123400, 24'hFEDC00, 1'b0, 16'h1234, 16'hFEDC};
        vecs[1] = '{24'h123480, 24'h000080, 1'b1, 16'h1235, 16'h0001};
        vecs[2] = '{24'h7FFFFF, 24'h800000, 1'b0, 16'h7FFF, 16'h8000};
        vecs[3] = '{24'hFFFF80, 24'hFFFF7F, 1'b1, 16'h0000, 16'hFFFF};
        vecs[4] = '{24'h7FFF80, 24'h000000, 1'b0, 16'h7FFF, 16'h0000};
`else
        vecs[0] = '{24'h123400, 24'hFEDC00, 1'b0, 16'h1234, 16'hFEDC};
        vecs[1] = '{24'h123480, 24'h000080, 1'b1, 16'h1234, 16'h0000};
        vecs[2] = '{24'h7FFFFF, 24'h800000, 1'b0, 16'h7FFF, 16'h8000};
        vecs[3] = '{24'hFFFF80, 24'hFFFF7F, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{24'h7FFF80, 24'h000000, 1'b0, 16'h7FFF, 16'h0000};
`endif
        bp_l   = '{24'h111100, 24'h222200, 24'h333300};
        bp_r   = '{24'hAAAA00, 24'hBBBB00, 24'hCCCC00};
        corner = '{24'h7FFFFF, 24'h800000, 24'h123480, 24'hFFFF80};

        // Reset state.
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        model_cnt = 0;
        exp_ready = 1'b0;
        hold_prev = 1'b0;
        chk("rst_o_valid",    32'(bus.o_valid),    32'd0);
        chk("rst_o_audio",    32'(bus.o_audio),    32'd0);
        chk("rst_o_is_left",  32'(bus.o_is_left),  32'd1);
        chk("rst_o_is_error", 32'(bus.o_is_error), 32'd0);
        chk("rst_i_ready",    32'(bus.i_ready),    32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_i_ready", 32'(bus.i_ready), 32'd1);

        // Single-frame vector table.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vecs[i].l, vecs[i].r, vecs[i].e, 1'b1);
            tick();
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            chk("vec_idle_after_push", 32'(bus.o_valid), 32'd0);
            tick();
            chk("vec_left", 32'({bus.o_valid, bus.o_audio, bus.o_is_left, bus.o_is_error}),
                32'({1'b1, vecs[i].xl, 1'b1, vecs[i].e}));
            tick();
            chk("vec_right", 32'({bus.o_valid, bus.o_audio, bus.o_is_left, bus.o_is_error}),
                32'({1'b1, vecs[i].xr, 1'b0, vecs[i].e}));
            tick();
            chk("vec_end_idle", 32'(bus.o_valid), 32'd0);
        end

        // Backpressure: three frames, only two fit.
        drive(1'b1, bp_l[0], bp_r[0], 1'b0, 1'b0);
        tick();
        drive(1'b1, bp_l[1], bp_r[1], 1'b0, 1'b0);
        tick();
        chk("bp_ready_low", 32'(bus.i_ready), 32'd0);
        drive(1'b1, bp_l[2], bp_r[2], 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_l1", 32'({bus.o_valid, bus.o_audio, bus.o_is_left}),
                32'({1'b1, ref_reduce(bp_l[0]), 1'b1}));
            tick();
        end
        bus.o_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("bp_stream", 32'({bus.o_valid, bus.o_audio, bus.o_is_left}),
                32'({1'b1, ref_reduce((k % 2 == 0) ? bp_l[k/2] : bp_r[k/2]), (k % 2 == 0)}));
            tick();
            if (last_push) bus.i_valid = 1'b0;
        end
        chk("bp_drained", 32'(bus.o_valid), 32'd0);
        chk("bp_third_taken", 32'(bus.i_valid), 32'd0);

        // Error flag follows its frame on both words.
        drive(1'b1, 24'h0A0000, 24'h0B0000, 1'b1, 1'b1);
        tick();
        drive(1'b1, 24'h0C0000, 24'h0D0000, 1'b0, 1'b1);
        tick();
        bus.i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("err_flag", 32'({bus.o_valid, bus.o_is_error}), 32'({1'b1, (k < 2)}));
            tick();
        end
        tick();

        // Reset while in RIGHT with another frame queued.
        drive(1'b1, 24'h010000, 24'h020000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 24'h030000, 24'h040000, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        chk("mid_in_right", 32'({bus.o_valid, bus.o_is_left}), 32'({1'b1, 1'b0}));
        reset = 1'b1;
        bus.o_ready = 1'b0;
        tick();
        chk("mid_rst_valid",   32'(bus.o_valid),   32'd0);
        chk("mid_rst_is_left", 32'(bus.o_is_left), 32'd1);
        reset = 1'b0;
        tick();
        drive(1'b1, 24'h050000, 24'h060000, 1'b0, 1'b1);
        tick();
        bus.i_valid = 1'b0;
        tick();
        chk("mid_restart_left", 32'({bus.o_valid, bus.o_audio, bus.o_is_left}),
            32'({1'b1, ref_reduce(24'h050000), 1'b1}));
        tick();
        tick();

        // Push while the last queued frame's right word is accepted.
        drive(1'b1, 24'h070000, 24'h080000, 1'b0, 1'b1);
        tick();
        bus.i_valid = 1'b0;
        tick();
        tick();
        chk("pp_in_right", 32'({bus.o_valid, bus.o_is_left}), 32'({1'b1, 1'b0}));
        drive(1'b1, 24'h090000, 24'h0A0000, 1'b1, 1'b1);
        tick();
        bus.i_valid = 1'b0;
        chk("pp_new_left", 32'({bus.o_valid, bus.o_audio, bus.o_is_left, bus.o_is_error}),
            32'({1'b1, ref_reduce(24'h090000), 1'b1, 1'b1}));
        chk("pp_ready", 32'(bus.i_ready), 32'd1);
        tick();
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rnd = $urandom;
            drive(rnd[0] | rnd[1],
                  (rnd[4:2] == 3'd0) ? corner[rnd[6:5]] : in_width'($urandom),
                  (rnd[9:7] == 3'd0) ? corner[rnd[11:10]] : in_width'($urandom),
                  rnd[12], rnd[13] | rnd[14] | rnd[15]);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) tick();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_idle", 32'(bus.o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
